// File: rtl/tri_pkg.sv
// -----------------------------------------------------------------------------
// tri_pkg
//   Shared types, widths and the edge-function helper for the triangle
//   inside/outside stage (tri_inside).
//
//   Contents:
//     DEF_D_BITS / DEF_Q_BITS : default coordinate width / fractional bits
//     W_E, W_X, W_D           : exact widths of edge vector, cross product
//                               component and dot product
//     state_t                 : sequencing FSM states
//     vec3_t                  : packed x,y,z vector ([0]=x, [1]=y, [2]=z)
//     edge_neg()              : sign of n . ((vb-va) x (p-va))
// -----------------------------------------------------------------------------
package tri_pkg;

    localparam int unsigned DEF_D_BITS = 32;
    localparam int unsigned DEF_Q_BITS = 16;

    // Exact growth: subtraction +1, product x2 then difference +1,
    // dot product (D + W_X) then a three-term sum +2.
    localparam int unsigned W_E = DEF_D_BITS + 1;
    localparam int unsigned W_X = 2 * DEF_D_BITS + 3;
    localparam int unsigned W_D = 3 * DEF_D_BITS + 5;

    typedef enum logic [2:0] {
        IDLE,
        E0,
        E1,
        E2,
        PUSH
    } state_t;

    typedef logic [2:0][DEF_D_BITS-1:0] vec3_t;

    // Returns 1 when p lies strictly on the outside of edge va->vb,
    // i.e. when n . ((vb - va) x (p - va)) < 0. Zero counts as inside.
    // Every intermediate is carried at full width, so the sign is exact.
    function automatic logic edge_neg(input vec3_t va, input vec3_t vb,
                                      input vec3_t p,  input vec3_t n);
        logic signed [W_E-1:0] e  [3];
        logic signed [W_E-1:0] c  [3];
        logic signed [W_X-1:0] ex [3];
        logic signed [W_X-1:0] cx [3];
        logic signed [W_X-1:0] x  [3];
        logic signed [W_D-1:0] nd [3];
        logic signed [W_D-1:0] xd [3];
        logic signed [W_D-1:0] d;

        for (int unsigned i = 0; i < 3; i++) begin
            e[i]  = $signed({vb[i][DEF_D_BITS-1], vb[i]})
                  - $signed({va[i][DEF_D_BITS-1], va[i]});
            c[i]  = $signed({p[i][DEF_D_BITS-1], p[i]})
                  - $signed({va[i][DEF_D_BITS-1], va[i]});
            ex[i] = {{(W_X - W_E){e[i][W_E-1]}}, e[i]};
            cx[i] = {{(W_X - W_E){c[i][W_E-1]}}, c[i]};
        end

        x[0] = ex[1] * cx[2] - ex[2] * cx[1];
        x[1] = ex[2] * cx[0] - ex[0] * cx[2];
        x[2] = ex[0] * cx[1] - ex[1] * cx[0];

        for (int unsigned i = 0; i < 3; i++) begin
            nd[i] = {{(W_D - DEF_D_BITS){n[i][DEF_D_BITS-1]}}, n[i]};
            xd[i] = {{(W_D - W_X){x[i][W_X-1]}}, x[i]};
        end

        d = nd[0] * xd[0] + nd[1] * xd[1] + nd[2] * xd[2];
        return d[W_D-1];
    endfunction

endpackage

// File: rtl/tri_inside_fifo.sv
// -----------------------------------------------------------------------------
// tri_inside_fifo
//   Generic first-word-fall-through FIFO used between pipeline stages.
//
//   Ports:
//     clock, reset   : clock, asynchronous active-low reset
//     wr_en_i        : push wr_data_i (honoured when not full, or when a pop
//                      happens in the same cycle)
//     wr_data_i      : write data
//     full_o         : count == DEPTH
//     rd_en_i        : pop the head (ignored while empty)
//     rd_data_o      : head entry, valid whenever empty_o = 0 (zero when empty)
//     empty_o        : count == 0
//   DEPTH must be a power of two; pointers wrap naturally.
// -----------------------------------------------------------------------------
module tri_inside_fifo #(
    parameter int unsigned WIDTH = 97,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

    // A pop in the same cycle frees the slot the push needs.
    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    // Head is forced to zero while empty so outputs are defined after reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/tri_inside.sv
// -----------------------------------------------------------------------------
// tri_inside
//   Edge-function inside/outside test for a ray/plane intersection point.
//   One shared cross/dot datapath is stepped over the three triangle edges
//   (E0: v0->v1, E1: v1->v2, E2: v2->v0); the edge signs are then combined
//   and {hit, p} is pushed into an output FWFT FIFO.
//
//   Ports:
//     clock, reset      : clock, asynchronous active-low reset
//     p_in              : intersection point x,y,z (signed Q16.16)
//     v0_in/v1_in/v2_in : triangle vertices, counter-clockwise about normal
//     tri_normal_in     : triangle normal (need not be unit length)
//     in_wr_en          : push request
//     in_full           : push is refused this cycle
//     hit               : FIFO head, 1 = inside or on the triangle
//     p_out             : FIFO head, point copied from p_in
//     out_rd_en         : pop FIFO head
//     out_empty         : FIFO empty
// -----------------------------------------------------------------------------
module tri_inside
    import tri_pkg::*;
#(
    parameter int unsigned D_BITS     = DEF_D_BITS,
    parameter int unsigned Q_BITS     = DEF_Q_BITS,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0][D_BITS-1:0] p_in,
    input  logic [2:0][D_BITS-1:0] v0_in,
    input  logic [2:0][D_BITS-1:0] v1_in,
    input  logic [2:0][D_BITS-1:0] v2_in,
    input  logic [2:0][D_BITS-1:0] tri_normal_in,
    input  logic                   in_wr_en,
    output logic                   in_full,
    output logic                   hit,
    output logic [2:0][D_BITS-1:0] p_out,
    input  logic                   out_rd_en,
    output logic                   out_empty
);

    localparam int unsigned FW = 3 * D_BITS + 1;

    // The edge function is sized by the package widths; the fixed-point
    // position does not matter because only the sign of an exact product
    // is used.
    if (D_BITS != DEF_D_BITS) begin : g_bad_width
        $error("tri_inside: D_BITS must equal tri_pkg::DEF_D_BITS");
    end
    if (Q_BITS >= D_BITS) begin : g_bad_q
        $error("tri_inside: Q_BITS must be smaller than D_BITS");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("tri_inside: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t                   state_q;
    logic [2:0][D_BITS-1:0]   p_q;
    logic [2:0][D_BITS-1:0]   v0_q;
    logic [2:0][D_BITS-1:0]   v1_q;
    logic [2:0][D_BITS-1:0]   v2_q;
    logic [2:0][D_BITS-1:0]   n_q;
    logic [2:0]               neg_q;

    logic [2:0][D_BITS-1:0]   va;
    logic [2:0][D_BITS-1:0]   vb;
    logic                     neg_d;
    logic                     accept;

    logic                     fifo_wr;
    logic [FW-1:0]            fifo_wdata;
    logic                     fifo_full;
    logic [FW-1:0]            fifo_rdata;

    // Busy for the whole E0..PUSH walk; a full FIFO also blocks accept, so
    // PUSH never finds the FIFO full (only pops can happen in between).
    assign in_full = (state_q != IDLE) | fifo_full;
    assign accept  = in_wr_en & ~in_full;

    // Edge endpoint selection for the shared datapath.
    always_comb begin
        va = v0_q;
        vb = v1_q;
        case (state_q)
            E1: begin
                va = v1_q;
                vb = v2_q;
            end
            E2: begin
                va = v2_q;
                vb = v0_q;
            end
            default: ;
        endcase
    end

    assign neg_d = edge_neg(va, vb, p_q, n_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            n_q     <= '0;
            neg_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        p_q     <= p_in;
                        v0_q    <= v0_in;
                        v1_q    <= v1_in;
                        v2_q    <= v2_in;
                        n_q     <= tri_normal_in;
                        state_q <= E0;
                    end
                end
                E0: begin
                    neg_q[0] <= neg_d;
                    state_q  <= E1;
                end
                E1: begin
                    neg_q[1] <= neg_d;
                    state_q  <= E2;
                end
                E2: begin
                    neg_q[2] <= neg_d;
                    state_q  <= PUSH;
                end
                PUSH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_wr    = (state_q == PUSH);
    assign fifo_wdata = {~|neg_q, p_q};

    tri_inside_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .full_o    (fifo_full),
        .rd_en_i   (out_rd_en),
        .rd_data_o (fifo_rdata),
        .empty_o   (out_empty)
    );

    assign hit   = fifo_rdata[FW-1];
    assign p_out = fifo_rdata[FW-2:0];

endmodule
